// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM encoding and fault check for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  // Illegal funct3 for the access direction, or an address not aligned to the access size.
  function automatic logic ls_is_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3;
    logic misal;
    if (we) bad_f3 = f3[2] | (f3 == 3'b011);
    else    bad_f3 = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    misal = ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
    return bad_f3 | misal;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - selects the addressed byte/half/word of a read word and extends it
module load_align_ext
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] w_s;

  assign w_s = rdata >> {offset, 3'b000};

  always_comb begin
    result = w_s;
    case (funct3)
      F3_B:    result = {{24{w_s[7]}}, w_s[7:0]};
      F3_BU:   result = {24'h0, w_s[7:0]};
      F3_H:    result = {{16{w_s[15]}}, w_s[15:0]};
      F3_HU:   result = {16'h0, w_s[15:0]};
      default: result = w_s;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit driving a req/gnt/rvalid data memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ls_valid,
  input  logic            ls_we,
  input  logic [2:0]      ls_funct3,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_stall,
  output logic            ls_done,
  output logic            ls_fault,
  output logic [XLEN-1:0] mem_read,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_e      r_state;
  logic [2:0]      r_funct3;
  logic [1:0]      r_offset;
  logic            r_done;
  logic            r_fault;
  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_mem_read;

  logic            w_fault;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;

  assign w_fault = ls_is_fault(ls_we, ls_funct3, ls_addr[1:0]);

  // Stores replicate the datum across all lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (ls_we) begin
      case (ls_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ls_addr[1:0];
          w_wdata = {4{ls_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {ls_addr[1], 1'b0};
          w_wdata = {2{ls_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ls_wdata;
        end
      endcase
    end
  end

  load_align_ext u_align (
    .rdata  (dmem_rdata),
    .offset (r_offset),
    .funct3 (r_funct3),
    .result (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_funct3   <= '0;
      r_offset   <= '0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_mem_read <= '0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ls_valid) begin
            if (w_fault) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_fault <= 1'b1;
            end else begin
              r_state  <= REQ;
              r_req    <= 1'b1;
              r_we     <= ls_we;
              r_addr   <= {ls_addr[XLEN-1:2], 2'b00};
              r_wdata  <= w_wdata;
              r_be     <= w_be;
              r_funct3 <= ls_funct3;
              r_offset <= ls_addr[1:0];
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            r_req <= 1'b0;
            if (r_we) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            r_mem_read <= w_load_data;
            r_state    <= DONE;
            r_done     <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

  assign ls_stall   = ls_valid & ~r_done;
  assign ls_done    = r_done;
  assign ls_fault   = r_fault;
  assign mem_read   = r_mem_read;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;

endmodule
